// File: rtl/dm_abstract_cmd_pkg.sv
// Shared debug-module types for the abstract-command stage.
// debug_types: cmderr codes, command layout, FSM states; debug: regno map.
package debug_types;

    typedef enum logic [2:0] {
        CMDERR_NONE       = 3'd0,
        CMDERR_BUSY       = 3'd1,
        CMDERR_NOTSUP     = 3'd2,
        CMDERR_EXCEPT     = 3'd3,
        CMDERR_HALTRESUME = 3'd4,
        CMDERR_BUS        = 3'd5
    } cmderr_t;

    typedef struct packed {
        logic [7:0]  cmdtype;
        logic        rsvd;
        logic [2:0]  aarsize;
        logic        postincrement;
        logic        postexec;
        logic        transfer;
        logic        write;
        logic [15:0] regno;
    } access_register_t;

    localparam logic [7:0] CMDTYPE_ACCESS_REG = 8'd0;
    localparam logic [2:0] AARSIZE_32         = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } absstate_t;

endpackage

package debug;

    // regno below this value addresses the CSR file directly
    localparam logic [15:0] CSR_REGNO_END = 16'h1000;
    localparam logic [15:0] GPR_BASE_DEF  = 16'h1000;
    localparam int          NUM_GPR_DEF   = 32;

endpackage

// File: rtl/dm_abstract_cmd_if.sv
// Register-file and CSR-file bus between dm_abstract_cmd and the hart.
// master: request side (DUT); slave: hart side returning rdata/ack.
interface dm_abstract_cmd_if;

    logic        oRfReq;
    logic        oRfWe;
    logic [4:0]  oRfAddr;
    logic [31:0] oRfWdata;
    logic [31:0] iRfRdata;
    logic        iRfAck;

    logic        oCsrReq;
    logic        oCsrWe;
    logic [11:0] oCsrAddr;
    logic [31:0] oCsrWdata;
    logic [31:0] iCsrRdata;
    logic        iCsrAck;

    modport master (
        output oRfReq, oRfWe, oRfAddr, oRfWdata,
        input  iRfRdata, iRfAck,
        output oCsrReq, oCsrWe, oCsrAddr, oCsrWdata,
        input  iCsrRdata, iCsrAck
    );

    modport slave (
        input  oRfReq, oRfWe, oRfAddr, oRfWdata,
        output iRfRdata, iRfAck,
        input  oCsrReq, oCsrWe, oCsrAddr, oCsrWdata,
        output iCsrRdata, iCsrAck
    );

endinterface

// File: rtl/dm_abstract_cmd.sv
// Abstract-command Access Register executor behind the DebugModule.
// Ports: iClk/iRst (async, active high); iCmdValid/iCmd/iData0/iHalted/
// iCmderrClr in; oBusy/oCmderr/oData0We/oData0 out; bus = GPR+CSR master.
// Option DM_ABSCMD_POSTINC_EN adds oRegnoUpd/oRegno (postincrement).
module dm_abstract_cmd
    import debug_types::*;
    import debug::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [15:0] GPR_BASE       = GPR_BASE_DEF,
    parameter int unsigned NUM_GPR        = NUM_GPR_DEF
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iCmdValid,
    input  logic [31:0] iCmd,
    input  logic [31:0] iData0,
    input  logic        iHalted,
    input  logic [2:0]  iCmderrClr,
    output logic        oBusy,
    output logic [2:0]  oCmderr,
    output logic        oData0We,
    output logic [31:0] oData0,
`ifdef DM_ABSCMD_POSTINC_EN
    output logic        oRegnoUpd,
    output logic [15:0] oRegno,
`endif
    dm_abstract_cmd_if.master bus
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_DONE  = DONE;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [16:0] GPR_END = 17'(GPR_BASE) + 17'(NUM_GPR);

    access_register_t w_cmd;
    assign w_cmd = access_register_t'(iCmd);

    logic w_unused;
    assign w_unused = w_cmd.rsvd;

    logic [1:0]    r_state;
    logic [2:0]    r_cmderr;
    logic [TW-1:0] r_tmo;
    logic          r_tgt_gpr;
    logic          r_write;
    logic [11:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
`ifdef DM_ABSCMD_POSTINC_EN
    logic          r_postinc;
    logic [15:0]   r_regno;
    logic [15:0]   r_regno_nxt;
`endif

    logic w_idle, w_issue, w_done;
    assign w_idle  = (r_state == S_IDLE);
    assign w_issue = (r_state == S_ISSUE);
    assign w_done  = (r_state == S_DONE);

    logic w_postinc_bad;
`ifdef DM_ABSCMD_POSTINC_EN
    assign w_postinc_bad = 1'b0;
`else
    assign w_postinc_bad = w_cmd.postincrement;
`endif

    logic w_notsup, w_is_csr, w_is_gpr;
    assign w_notsup = (w_cmd.cmdtype != CMDTYPE_ACCESS_REG)
                    || (w_cmd.aarsize != AARSIZE_32)
                    || w_cmd.postexec
                    || w_postinc_bad;
    assign w_is_csr = (w_cmd.regno < CSR_REGNO_END);
    assign w_is_gpr = ({1'b0, w_cmd.regno} >= {1'b0, GPR_BASE})
                    && ({1'b0, w_cmd.regno} < GPR_END);

    // only the ack of the bus actually targeted counts
    logic        w_ack;
    logic [31:0] w_rdata;
    assign w_ack   = w_issue && (r_tgt_gpr ? bus.iRfAck : bus.iCsrAck);
    assign w_rdata = r_tgt_gpr ? bus.iRfRdata : bus.iCsrRdata;

    logic w_timeout;
    assign w_timeout = w_issue && !w_ack && (r_tmo == TMO_LAST);

    logic w_start;
    assign w_start = w_idle && iCmdValid && (r_cmderr == CMDERR_NONE)
                   && !w_notsup && w_cmd.transfer && iHalted
                   && (w_is_csr || w_is_gpr);

    logic [2:0] w_err_set;
    always_comb begin
        w_err_set = CMDERR_NONE;
        if (iCmdValid && !w_idle) begin
            w_err_set = CMDERR_BUSY;
        end else if (iCmdValid) begin
            if (w_notsup)
                w_err_set = CMDERR_NOTSUP;
            else if (!w_cmd.transfer)
                w_err_set = CMDERR_NONE;
            else if (!iHalted)
                w_err_set = CMDERR_HALTRESUME;
            else if (!w_is_csr && !w_is_gpr)
                w_err_set = CMDERR_EXCEPT;
        end
        if (w_timeout)
            w_err_set = CMDERR_BUS;
    end

    // sticky once non-zero; the W1C mask also strips a same-cycle set
    logic [2:0] w_cmderr_nxt;
    assign w_cmderr_nxt = ((r_cmderr == CMDERR_NONE) ? w_err_set : r_cmderr)
                        & ~iCmderrClr;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state     <= S_IDLE;
            r_cmderr    <= CMDERR_NONE;
            r_tmo       <= '0;
            r_tgt_gpr   <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
`ifdef DM_ABSCMD_POSTINC_EN
            r_postinc   <= 1'b0;
            r_regno     <= '0;
            r_regno_nxt <= '0;
`endif
        end else begin
            r_cmderr <= w_cmderr_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state   <= S_ISSUE;
                        r_tgt_gpr <= !w_is_csr;
                        r_write   <= w_cmd.write;
                        r_addr    <= w_is_csr ? w_cmd.regno[11:0]
                                              : 12'(w_cmd.regno - GPR_BASE);
                        r_wdata   <= iData0;
                        r_tmo     <= '0;
`ifdef DM_ABSCMD_POSTINC_EN
                        r_postinc <= w_cmd.postincrement;
                        r_regno   <= w_cmd.regno;
`endif
                    end
                end
                S_ISSUE: begin
                    if (w_ack) begin
                        if (!r_write)
                            r_rdata <= w_rdata;
`ifdef DM_ABSCMD_POSTINC_EN
                        r_regno_nxt <= r_regno + 16'd1;
`endif
                        r_state <= S_DONE;
                    end else if (w_timeout) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // request lines decode from state so a reset drops them at once
    assign bus.oRfReq    = w_issue && r_tgt_gpr;
    assign bus.oRfWe     = w_issue && r_tgt_gpr && r_write;
    assign bus.oRfAddr   = r_addr[4:0];
    assign bus.oRfWdata  = r_wdata;
    assign bus.oCsrReq   = w_issue && !r_tgt_gpr;
    assign bus.oCsrWe    = w_issue && !r_tgt_gpr && r_write;
    assign bus.oCsrAddr  = r_addr;
    assign bus.oCsrWdata = r_wdata;

    assign oBusy    = !w_idle;
    assign oCmderr  = r_cmderr;
    assign oData0We = w_done && !r_write;
    assign oData0   = r_rdata;
`ifdef DM_ABSCMD_POSTINC_EN
    assign oRegnoUpd = w_done && r_postinc;
    assign oRegno    = r_regno_nxt;
`endif

endmodule

// File: tb/tb_dm_abstract_cmd.sv
// Directed table-driven bench for dm_abstract_cmd.
// Covers GPR/CSR access, cmderr codes, busy collision, timeout, reset.
module tb_dm_abstract_cmd;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iCmdValid;
    logic [31:0] iCmd;
    logic [31:0] iData0;
    logic        iHalted;
    logic [2:0]  iCmderrClr;
    logic        oBusy;
    logic [2:0]  oCmderr;
    logic        oData0We;
    logic [31:0] oData0;
`ifdef DM_ABSCMD_POSTINC_EN
    logic        oRegnoUpd;
    logic [15:0] oRegno;
`endif

    dm_abstract_cmd_if bus();

    dm_abstract_cmd dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iCmdValid  (iCmdValid),
        .iCmd       (iCmd),
        .iData0     (iData0),
        .iHalted    (iHalted),
        .iCmderrClr (iCmderrClr),
        .oBusy      (oBusy),
        .oCmderr    (oCmderr),
        .oData0We   (oData0We),
        .oData0     (oData0),
`ifdef DM_ABSCMD_POSTINC_EN
        .oRegnoUpd  (oRegnoUpd),
        .oRegno     (oRegno),
`endif
        .bus        (bus)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] data0;
        logic        halted;
        logic [2:0]  clr;
        int          ack_n;
        logic [31:0] rdata;
        int          coll;
        int          exp_rf;
        int          exp_csr;
        logic [11:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata;
        int          exp_d0we;
        logic [31:0] exp_d0;
        logic [2:0]  exp_err;
        int          exp_busy;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] cmd, input logic [31:0] data0,
        input logic halted, input logic [2:0] clr, input int ack_n,
        input logic [31:0] rdata, input int coll,
        input int exp_rf, input int exp_csr, input logic [11:0] exp_addr,
        input logic exp_we, input logic [31:0] exp_wdata,
        input int exp_d0we, input logic [31:0] exp_d0,
        input logic [2:0] exp_err, input int exp_busy);
        vec_t v;
        v.cmd = cmd; v.data0 = data0; v.halted = halted; v.clr = clr;
        v.ack_n = ack_n; v.rdata = rdata; v.coll = coll;
        v.exp_rf = exp_rf; v.exp_csr = exp_csr; v.exp_addr = exp_addr;
        v.exp_we = exp_we; v.exp_wdata = exp_wdata;
        v.exp_d0we = exp_d0we; v.exp_d0 = exp_d0;
        v.exp_err = exp_err; v.exp_busy = exp_busy;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h exp=%h", nm, idx, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int nrf, ncsr, nbusy, nd0, nwe;
        logic [11:0] addr;
        logic [31:0] wd, d0;
        nrf = 0; ncsr = 0; nbusy = 0; nd0 = 0; nwe = 0;
        addr = '0; wd = '0; d0 = '0;
        @(negedge iClk);
        iCmderrClr = v.clr;
        @(negedge iClk);
        iCmderrClr = 3'd0;
        iCmd = v.cmd; iData0 = v.data0; iHalted = v.halted;
        iCmdValid = 1'b1;
        @(negedge iClk);
        iCmdValid = 1'b0;
        for (int c = 0; c < 80; c++) begin
            bus.iRfAck = 1'b0; bus.iCsrAck = 1'b0;
            bus.iRfRdata = '0; bus.iCsrRdata = '0;
            if (oBusy) nbusy++;
            if (oData0We) begin nd0++; d0 = oData0; end
            if (bus.oRfReq) begin
                nrf++;
                addr = 12'(bus.oRfAddr); wd = bus.oRfWdata;
                if (bus.oRfWe) nwe++;
                if (nrf == v.ack_n) begin
                    bus.iRfAck = 1'b1; bus.iRfRdata = v.rdata;
                end
            end
            if (bus.oCsrReq) begin
                ncsr++;
                addr = bus.oCsrAddr; wd = bus.oCsrWdata;
                if (bus.oCsrWe) nwe++;
                if (ncsr == v.ack_n) begin
                    bus.iCsrAck = 1'b1; bus.iCsrRdata = v.rdata;
                end
            end
            iCmdValid = (c + 1 == v.coll);
            @(negedge iClk);
        end
        iCmdValid = 1'b0;
        chk("rf_req_cycles", idx, nrf, v.exp_rf);
        chk("csr_req_cycles", idx, ncsr, v.exp_csr);
        chk("busy_cycles", idx, nbusy, v.exp_busy);
        chk("data0we_pulses", idx, nd0, v.exp_d0we);
        chk("cmderr", idx, oCmderr, v.exp_err);
        chk("we_cycles", idx, nwe,
            v.exp_we ? v.exp_rf + v.exp_csr : 0);
        if (v.exp_rf + v.exp_csr > 0) chk("addr", idx, addr, v.exp_addr);
        if (v.exp_we) chk("wdata", idx, wd, v.exp_wdata);
        if (v.exp_d0we > 0) chk("data0", idx, d0, v.exp_d0);
    endtask

    vec_t vecs[15];

    initial begin
        vecs[0]  = mk(32'h0022_1005, 32'h0, 1, 7, 3, 32'hDEAD_BEEF, 0,
                      3, 0, 12'h005, 0, 32'h0, 1, 32'hDEAD_BEEF, 0, 4);
        vecs[1]  = mk(32'h0023_0341, 32'h8000_0000, 1, 7, 1, 32'h0, 0,
                      0, 1, 12'h341, 1, 32'h8000_0000, 0, 32'h0, 0, 2);
        vecs[2]  = mk(32'h0022_1005, 32'h0, 0, 7, 1, 32'h0, 0,
                      0, 0, 12'h0, 0, 32'h0, 0, 32'h0, 4, 0);
        vecs[3]  = mk(32'h0022_1020, 32'h0, 1, 7, 1, 32'h0, 0,
                      0, 0, 12'h0, 0, 32'h0, 0, 32'h0, 3, 0);
        vecs[4]  = mk(32'h0032_1005, 32'h0, 1, 7, 1, 32'h0, 0,
                      0, 0, 12'h0, 0, 32'h0, 0, 32'h0, 2, 0);
        vecs[5]  = mk(32'h0026_1005, 32'h0, 1, 0, 1, 32'h0, 0,
                      0, 0, 12'h0, 0, 32'h0, 0, 32'h0, 2, 0);
        vecs[6]  = mk(32'h0022_1005, 32'h0, 1, 0, 1, 32'h0, 0,
                      0, 0, 12'h0, 0, 32'h0, 0, 32'h0, 2, 0);
        vecs[7]  = mk(32'h0122_1005, 32'h0, 1, 7, 1, 32'h0, 0,
                      0, 0, 12'h0, 0, 32'h0, 0, 32'h0, 2, 0);
        vecs[8]  = mk(32'h0020_1005, 32'h0, 0, 7, 1, 32'h0, 0,
                      0, 0, 12'h0, 0, 32'h0, 0, 32'h0, 0, 0);
`ifdef DM_ABSCMD_POSTINC_EN
        vecs[9]  = mk(32'h002A_1005, 32'h0, 1, 7, 1, 32'h0000_5A5A, 0,
                      1, 0, 12'h005, 0, 32'h0, 1, 32'h0000_5A5A, 0, 2);
`else
        vecs[9]  = mk(32'h002A_1005, 32'h0, 1, 7, 1, 32'h0000_5A5A, 0,
                      0, 0, 12'h0, 0, 32'h0, 0, 32'h0, 2, 0);
`endif
        vecs[10] = mk(32'h0022_0FFF, 32'h0, 1, 7, 2, 32'hA5A5_0001, 0,
                      0, 2, 12'hFFF, 0, 32'h0, 1, 32'hA5A5_0001, 0, 3);
        vecs[11] = mk(32'h0023_1000, 32'h0000_00FF, 1, 7, 1, 32'h0, 0,
                      1, 0, 12'h000, 1, 32'h0000_00FF, 0, 32'h0, 0, 2);
        vecs[12] = mk(32'h0022_1003, 32'h0, 1, 7, 3, 32'h0BAD_F00D, 1,
                      3, 0, 12'h003, 0, 32'h0, 1, 32'h0BAD_F00D, 1, 4);
        vecs[13] = mk(32'h0023_101F, 32'h1234_5678, 1, 7, 0, 32'h0, 0,
                      64, 0, 12'h01F, 1, 32'h1234_5678, 0, 32'h0, 5, 64);
        vecs[14] = mk(32'h0022_101F, 32'h0, 1, 7, 1, 32'h1122_3344, 0,
                      1, 0, 12'h01F, 0, 32'h0, 1, 32'h1122_3344, 0, 2);

        iRst = 1'b1; iCmdValid = 1'b0; iCmd = '0; iData0 = '0;
        iHalted = 1'b1; iCmderrClr = '0;
        bus.iRfAck = 1'b0; bus.iCsrAck = 1'b0;
        bus.iRfRdata = '0; bus.iCsrRdata = '0;

        repeat (2) @(negedge iClk);
        chk("rst_busy", 0, oBusy, 0);
        chk("rst_cmderr", 0, oCmderr, 0);
        chk("rst_rfreq", 0, bus.oRfReq, 0);
        chk("rst_csrreq", 0, bus.oCsrReq, 0);
        chk("rst_d0we", 0, oData0We, 0);
        chk("rst_data0", 0, oData0, 0);
        iRst = 1'b0;

        // stray acks while idle must not produce a read-back
        @(negedge iClk);
        bus.iRfAck = 1'b1; bus.iCsrAck = 1'b1;
        bus.iRfRdata = 32'h5555_5555; bus.iCsrRdata = 32'h6666_6666;
        @(negedge iClk);
        bus.iRfAck = 1'b0; bus.iCsrAck = 1'b0;
        chk("stray_ack_busy", 0, oBusy, 0);
        chk("stray_ack_d0we", 0, oData0We, 0);
        @(negedge iClk);
        chk("stray_ack_data0", 0, oData0, 0);

        // clear mask wins over an error raised in the same cycle
        iHalted = 1'b0; iCmd = 32'h0022_1005;
        iCmdValid = 1'b1; iCmderrClr = 3'd7;
        @(negedge iClk);
        iCmdValid = 1'b0; iCmderrClr = 3'd0; iHalted = 1'b1;
        chk("clr_priority", 0, oCmderr, 0);

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

`ifdef DM_ABSCMD_POSTINC_EN
        @(negedge iClk);
        iCmderrClr = 3'd7;
        @(negedge iClk);
        iCmderrClr = 3'd0; iCmd = 32'h002A_101F; iCmdValid = 1'b1;
        @(negedge iClk);
        iCmdValid = 1'b0;
        chk("pi_req", 0, bus.oRfReq, 1);
        bus.iRfAck = 1'b1; bus.iRfRdata = 32'h77;
        @(negedge iClk);
        bus.iRfAck = 1'b0;
        chk("pi_upd", 0, oRegnoUpd, 1);
        chk("pi_regno", 0, oRegno, 32'h1020);
        @(negedge iClk);
        chk("pi_upd_off", 0, oRegnoUpd, 0);
        run_vec(mk(32'h0022_1020, 32'h0, 1, 0, 1, 32'h0, 0,
                   0, 0, 12'h0, 0, 32'h0, 0, 32'h0, 3, 0), 15);
`endif

        // asynchronous reset in the middle of ISSUE
        @(negedge iClk);
        iCmderrClr = 3'd7;
        @(negedge iClk);
        iCmderrClr = 3'd0; iCmd = 32'h0022_1007; iCmdValid = 1'b1;
        @(negedge iClk);
        iCmdValid = 1'b0;
        @(negedge iClk);
        chk("arst_pre_req", 0, bus.oRfReq, 1);
        #2 iRst = 1'b1;
        #1;
        chk("arst_req", 0, bus.oRfReq, 0);
        chk("arst_busy", 0, oBusy, 0);
        @(negedge iClk);
        iRst = 1'b0;
        @(negedge iClk);
        chk("arst_idle", 0, oBusy, 0);
        chk("arst_cmderr", 0, oCmderr, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_abstract_cmd.md
Name: dm_abstract_cmd

Overview:
- Abstract-command execution stage directly downstream of DebugModule.
- Consumes the latched command/data0 registers and performs Access Register transfers to the hart register file (GPR) or CSR file over two bus-master ports.
- Reports busy and cmderr back to the DebugModule's abstractcs, and returns read data for data0.

Parameters:
- TIMEOUT_CYCLES, 64, cycles to wait for a bus ack before aborting with a bus error.
- GPR_BASE, 16'h1000, regno of x0.
- NUM_GPR, 32, number of GPRs mapped from GPR_BASE.

Ports:
- iClk  input  1  system clock
- iRst  input  1  asynchronous active-high reset
- iCmdValid  input  1  one-cycle pulse: DMI write to command
- iCmd  input  32  command word (cmdtype[31:24], aarsize[22:20], postincrement[19], postexec[18], transfer[17], write[16], regno[15:0])
- iData0  input  32  current data0 contents
- iHalted  input  1  hart is halted
- iCmderrClr  input  3  W1C mask from a DMI write to abstractcs.cmderr
- oBusy  output  1  abstractcs.busy
- oCmderr  output  3  abstractcs.cmderr
- oData0We  output  1  one-cycle strobe: load oData0 into data0
- oData0  output  32  read-back data
- oRfReq, oRfWe  output  1 each  GPR bus request and write enable
- oRfAddr  output  5  GPR index
- oRfWdata  output  32  GPR write data
- iRfRdata  input  32  GPR read data
- iRfAck  input  1  GPR ack
- oCsrReq, oCsrWe  output  1 each  CSR bus request and write enable
- oCsrAddr  output  12  CSR address
- oCsrWdata  output  32  CSR write data
- iCsrRdata  input  32  CSR read data
- iCsrAck  input  1  CSR ack

Behaviour:
- Reset (async, iRst=1): state IDLE; all outputs 0; cmderr 0; timeout counter 0.
- cmderr encoding: 0 none, 1 busy, 2 notsupported, 3 exception, 4 haltresume, 5 bus.
  - cmderr is sticky: it only changes from 0 to non-zero.
  - Cleared bitwise by iCmderrClr on any cycle; the clear takes priority over a same-cycle set.
- IDLE, on iCmdValid, checks in priority order:
  - cmderr != 0 → command ignored, no state change.
  - cmdtype != 0, aarsize != 2, or postexec = 1 → cmderr = 2.
  - transfer = 0 → accepted, no bus access, remain IDLE (no-op).
  - !iHalted → cmderr = 4.
  - regno < 0x1000 → CSR target; GPR_BASE ≤ regno < GPR_BASE+NUM_GPR → GPR target; otherwise cmderr = 3.
  - Valid → go to ISSUE; oBusy = 1 from the next cycle.
- ISSUE:
  - Drive oXReq = 1 with addr, we = write, and wdata = iData0 captured at accept. Hold these stable until ack.
  - Ack is a single-cycle pulse. In the ack cycle:
    - If read, capture rdata.
    - Deassert req the next cycle; go to DONE.
  - Timeout counter counts cycles in ISSUE. At TIMEOUT_CYCLES without ack: drop req, cmderr = 5, go to IDLE.
- DONE (1 cycle):
  - If read, oData0We = 1 and oData0 = captured data.
  - Go to IDLE; oBusy = 0 the following cycle.
- Latency for a zero-wait read: accept at cycle 0, req cycles 1–n, DONE at n+1, busy low at n+2.
- iCmdValid while busy: cmderr = 1 (if currently 0); the in-flight command still completes normally.
- An ack arriving outside ISSUE is ignored.
- Reset mid-transfer aborts immediately: req drops asynchronously.

Optional Feature:
- DM_ABSCMD_POSTINC_EN
  - Defined: postincrement = 1 is accepted. After a successful transfer, regno is incremented by 1 (16-bit wrap). The new value is output on extra ports oRegnoUpd (1-cycle strobe in DONE) and oRegno[15:0], so the DM updates command.regno.
  - Undefined: postincrement = 1 gives cmderr = 2; these ports do not exist.

Decomposition:
- Shared package debug_types:
  - cmderr_t enum
  - abstract command struct (access_register_t)
  - aarsize and cmdtype constants
  - absstate_t {IDLE, ISSUE, DONE}
- Package debug: regno range constants.
- No sub-module: the timeout counter is inline.

Test Plan:
- Halted, read GPR: cmd 0x0022_1005 (transfer, aarsize 2, regno 0x1005), rf ack after 2 cycles with 0xDEADBEEF → oRfAddr = 5, oData0We pulse with 0xDEADBEEF, cmderr = 0, busy high for 4 cycles.
- Write CSR: cmd 0x0023_0341, iData0 = 0x8000_0000 → oCsrReq, we = 1, addr 0x341, wdata 0x8000_0000; no oData0We.
- Hart running, valid cmd → cmderr = 4, no req. iCmderrClr = 7 → cmderr = 0. Next cmd while busy → cmderr = 1 and the first transfer still completes.
- aarsize = 3 → cmderr = 2. regno 0x1020 → cmderr = 3. Unsupported command with cmderr already 2 → stays 2.
- No ack for 64 cycles → req drops in cycle 65, cmderr = 5. Async reset asserted during ISSUE → req low immediately, busy 0.
- With DM_ABSCMD_POSTINC_EN, postincrement read of 0x101F → oRegno = 0x1020, strobe in DONE. Follow-up cmd → cmderr = 3.
